retire_trace_buffer: RTL and testbench
======================================

# retire_trace_buffer

Retire-side trace buffer that sits directly downstream of the pipelined RV32I core's retire port. Every cycle the core asserts its retire strobe, the block captures one retire record (PC, instruction, register write-back, memory access). It queues the records in a FIFO and drains them over a valid/ready stream to a logger or debug link. Overflow is counted rather than stalling the core, since the core has no back-pressure input.

## Interface
- Depth, 16: FIFO entries; power of two, at least 2.
- DropCntW, 16: width of the saturating drop counter.
- clk_i  input  1  system clock, rising-edge.
- rstn_i  input  1  asynchronous, active-low reset.
- clear_i  input  1  synchronous flush of FIFO and status.
- update_i  input  1  retire strobe; one record per cycle while high.
- pc_i  input  XLEN  retired PC.
- instr_i  input  XLEN  retired instruction.
- reg_addr_i  input  5  destination register.
- reg_data_i  input  XLEN  write-back data.
- mem_addr_i  input  XLEN  memory address.
- mem_data_i  input  XLEN  memory write data.
- mem_wrt_i  input  1  memory write enable.
- trace_valid_o  output  1  head record valid.
- trace_ready_i  input  1  consumer accepts the head record.
- trace_rec_o  output  $bits(retire_rec_t)  head record.
- count_o  output  $clog2(Depth)+1  current occupancy.
- overflow_o  output  1  sticky; set when any record is dropped.
- drop_cnt_o  output  DropCntW  saturating count of dropped records.

## Operation
- The push condition is update_i high at a rising edge.
- The record written on a push is {pc_i, instr_i, reg_addr_i, reg_data_i, mem_addr_i, mem_data_i, mem_wrt_i}, sampled at that edge.
- The pop condition is trace_valid_o and trace_ready_i both high at a rising edge.
- FIFO is first-word fall-through from registered storage.
  - trace_rec_o always shows the head entry while trace_valid_o is high.
  - trace_rec_o content is don't-care while trace_valid_o is low.
- Full FIFO with a push and no pop:
  - The record is discarded and the FIFO is unchanged.
  - overflow_o is set.
  - drop_cnt_o increments, holding at all-ones (it does not wrap).
- Full FIFO with a push and a pop in the same cycle: both are accepted, with no drop and count unchanged.
- Empty FIFO with a push:
  - There is no combinational bypass.
  - trace_valid_o rises the cycle after the push.
  - A pop cannot occur that same cycle because trace_valid_o is low.
- Read and write pointers are $clog2(Depth)+1 bits.
  - The extra MSB distinguishes full from empty.
  - Pointers wrap modulo 2·Depth.
- clear_i has priority over push and pop in the same cycle.
  - Pointers go to 0 and count_o to 0.
  - overflow_o and drop_cnt_o go to 0.
  - A push asserted in the clear cycle is discarded and is not counted as a drop.
- Record contents are not filtered or modified.

## Timing
- Reset values (asynchronous, while rstn_i is low):
  - trace_valid_o = 0, count_o = 0, overflow_o = 0, drop_cnt_o = 0.
  - Pointers = 0.
  - Storage contents are not reset.
- Latency from push edge to trace_valid_o high is 1 cycle.
- Throughput is one push and one pop per cycle, sustained.
- count_o, overflow_o and drop_cnt_o are registered and reflect the state after the last edge.
- A reset assertion mid-stream discards all queued records immediately; the consumer must tolerate trace_valid_o dropping without a handshake.
- Once trace_valid_o is asserted, trace_rec_o is stable until popped, clear_i or reset.

## Structure
- riscv_pkg holds the shared definitions:
  - typedef retire_rec_t, a packed struct with fields pc, instr, reg_addr, reg_data, mem_addr, mem_data, mem_wrt.
  - XLEN is reused from the package.
- One sub-module, sync_fifo, is parameterised on element width and Depth and exposes push/pop/full/empty/count.
- The top level adds the drop/overflow logic and the handshake mapping.

## Test plan
- Single push: after reset, update_i pulses once with pc_i=0x00000004 and instr_i=0x00500093.
  - Next cycle: trace_valid_o=1, trace_rec_o.pc=0x4, count_o=1.
  - After one ready cycle: valid=0, count_o=0.
- Fill and overflow: Depth=16, 20 consecutive pushes with trace_ready_i=0.
  - count_o=16, overflow_o=1, drop_cnt_o=4.
  - Draining returns PCs 0x0 through 0x3C in order.
- Full with simultaneous push and pop: FIFO full, push and ready in the same cycle.
  - No drop occurs, count_o stays at 16.
  - The new record appears last on drain.
- Pointer wrap: 40 pushes interleaved with 1-cycle-delayed pops.
  - The output PC sequence matches the input sequence exactly.
  - drop_cnt_o=0.
- Clear priority: FIFO holds 5 entries, overflow_o=1, then clear_i and update_i high in the same cycle.
  - Next cycle: count_o=0, valid=0, overflow_o=0, drop_cnt_o=0.
- Saturation and async reset:
  - DropCntW=3 with 12 drops gives drop_cnt_o=7.
  - Asserting rstn_i low between clock edges zeroes every output before the next clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I retire-side definitions: data width and the retire record layout.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic [4:0]      reg_addr;
      logic [XLEN-1:0] reg_data;
      logic [XLEN-1:0] mem_addr;
      logic [XLEN-1:0] mem_data;
      logic            mem_wrt;
   } retire_rec_t;

   localparam int RecW = $bits(retire_rec_t);

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO over registered storage; pointers carry an extra
// wrap bit so full and empty are distinguishable without a separate counter.
module sync_fifo #(
   parameter int Width = 8,
   parameter int Depth = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [Width-1:0]         wdata,
   output logic [Width-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   count
);

   localparam int AW = $clog2(Depth);

   logic [Width-1:0] mem [Depth];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count = wptr - rptr;

   // A pop frees the head slot this edge, so a full FIFO can still take a push.
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (clear) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !clear) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures one retire record per strobe into a FIFO and drains it over valid/ready;
// records arriving while full are dropped and counted since the core cannot stall.
module retire_trace_buffer
   import riscv_pkg::*;
#(
   parameter int Depth    = 16,
   parameter int DropCntW = 16
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     clear_i,
   input  logic                     update_i,
   input  logic [XLEN-1:0]          pc_i,
   input  logic [XLEN-1:0]          instr_i,
   input  logic [4:0]               reg_addr_i,
   input  logic [XLEN-1:0]          reg_data_i,
   input  logic [XLEN-1:0]          mem_addr_i,
   input  logic [XLEN-1:0]          mem_data_i,
   input  logic                     mem_wrt_i,
   output logic                     trace_valid_o,
   input  logic                     trace_ready_i,
   output logic [RecW-1:0]          trace_rec_o,
   output logic [$clog2(Depth):0]   count_o,
   output logic                     overflow_o,
   output logic [DropCntW-1:0]      drop_cnt_o
);

   function automatic logic [DropCntW-1:0] sat_inc(input logic [DropCntW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   retire_rec_t rec_in;
   logic        full;
   logic        empty;
   logic        pop;
   logic        drop;

   assign rec_in = '{pc:       pc_i,
                     instr:    instr_i,
                     reg_addr: reg_addr_i,
                     reg_data: reg_data_i,
                     mem_addr: mem_addr_i,
                     mem_data: mem_data_i,
                     mem_wrt:  mem_wrt_i};

   assign trace_valid_o = !empty;
   assign pop           = trace_valid_o && trace_ready_i;
   // A push into a full FIFO survives only when the head leaves the same edge.
   assign drop          = update_i && full && !pop && !clear_i;

   sync_fifo #(
      .Width (RecW),
      .Depth (Depth)
   ) u_fifo (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .clear (clear_i),
      .push  (update_i),
      .pop   (pop),
      .wdata (rec_in),
      .rdata (trace_rec_o),
      .full  (full),
      .empty (empty),
      .count (count_o)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
      end else if (clear_i) begin
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
      end else if (drop) begin
         overflow_o <= 1'b1;
         drop_cnt_o <= sat_inc(drop_cnt_o);
      end
   end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: a Depth=16 instance with a 16-bit and a
// 3-bit drop counter share every input so saturation is checked alongside.
module tb_retire_trace_buffer;
   import riscv_pkg::*;

   logic            clk;
   logic            rstn;
   logic            clear;
   logic            update;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] instr;
   logic [4:0]      reg_addr;
   logic [XLEN-1:0] reg_data;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_data;
   logic            mem_wrt;
   logic            ready;

   logic            valid;
   logic [RecW-1:0] trace_rec;
   logic [4:0]      count;
   logic            overflow;
   logic [15:0]     drop_cnt;

   logic            valid3;
   logic [RecW-1:0] trace_rec3;
   logic [4:0]      count3;
   logic            overflow3;
   logic [2:0]      drop_cnt3;

   retire_rec_t     rec;
   assign rec = trace_rec;

   int tests = 0;
   int fails = 0;

   retire_trace_buffer #(.Depth(16), .DropCntW(16)) dut (
      .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .update_i(update),
      .pc_i(pc), .instr_i(instr), .reg_addr_i(reg_addr), .reg_data_i(reg_data),
      .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_wrt_i(mem_wrt),
      .trace_valid_o(valid), .trace_ready_i(ready), .trace_rec_o(trace_rec),
      .count_o(count), .overflow_o(overflow), .drop_cnt_o(drop_cnt)
   );

   retire_trace_buffer #(.Depth(16), .DropCntW(3)) dut3 (
      .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .update_i(update),
      .pc_i(pc), .instr_i(instr), .reg_addr_i(reg_addr), .reg_data_i(reg_data),
      .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_wrt_i(mem_wrt),
      .trace_valid_o(valid3), .trace_ready_i(ready), .trace_rec_o(trace_rec3),
      .count_o(count3), .overflow_o(overflow3), .drop_cnt_o(drop_cnt3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0; clear = 1'b0; update = 1'b0; ready = 1'b0;
      pc = '0; instr = '0; reg_addr = 5'd0; reg_data = '0;
      mem_addr = '0; mem_data = '0; mem_wrt = 1'b0;

      // Reset state
      step(); step();
      check("rst_valid", valid, 1'b0);
      check("rst_count", count, 5'd0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_drop", drop_cnt, 16'd0);
      @(negedge clk);
      rstn = 1'b1;
      step();

      // Single push then single pop
      update = 1'b1; pc = 32'h0000_0004; instr = 32'h0050_0093;
      reg_addr = 5'd1; reg_data = 32'h5; mem_wrt = 1'b0;
      check("push_no_bypass", valid, 1'b0);
      step();
      update = 1'b0;
      check("single_valid", valid, 1'b1);
      check("single_pc", rec.pc, 32'h4);
      check("single_instr", rec.instr, 32'h0050_0093);
      check("single_rd", rec.reg_addr, 5'd1);
      check("single_count", count, 5'd1);
      ready = 1'b1;
      step();
      ready = 1'b0;
      check("single_pop_valid", valid, 1'b0);
      check("single_pop_count", count, 5'd0);

      // Fill with 20 pushes, ready low: 4 drops
      instr = 32'h0000_0013; reg_addr = 5'd0; reg_data = '0;
      for (int i = 0; i < 20; i++) begin
         update = 1'b1; pc = 32'(i * 4);
         step();
      end
      update = 1'b0;
      check("fill_count", count, 5'd16);
      check("fill_overflow", overflow, 1'b1);
      check("fill_drop", drop_cnt, 16'd4);
      check("fill_drop3", drop_cnt3, 3'd4);
      ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("fill_drain_valid", valid, 1'b1);
         check("fill_drain_pc", rec.pc, 32'(i * 4));
         step();
      end
      ready = 1'b0;
      check("fill_drained_valid", valid, 1'b0);
      check("fill_drained_count", count, 5'd0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 16; i++) begin
         update = 1'b1; pc = 32'h100 + 32'(i * 4);
         step();
      end
      check("full_count", count, 5'd16);
      check("full_drop_held", drop_cnt, 16'd4);
      update = 1'b1; ready = 1'b1; pc = 32'h200; mem_wrt = 1'b1; mem_addr = 32'h8000_0000;
      step();
      update = 1'b0; mem_wrt = 1'b0; mem_addr = '0;
      check("pushpop_count", count, 5'd16);
      check("pushpop_drop", drop_cnt, 16'd4);
      for (int i = 1; i < 16; i++) begin
         check("pushpop_drain_pc", rec.pc, 32'h100 + 32'(i * 4));
         step();
      end
      check("pushpop_last_pc", rec.pc, 32'h200);
      check("pushpop_last_wrt", rec.mem_wrt, 1'b1);
      check("pushpop_last_maddr", rec.mem_addr, 32'h8000_0000);
      step();
      ready = 1'b0;
      check("pushpop_empty", valid, 1'b0);

      // Clear status before the wrap test
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_overflow", overflow, 1'b0);
      check("clr_drop", drop_cnt, 16'd0);

      // Pointer wrap: 40 pushes, each popped one cycle later
      update = 1'b1; pc = 32'h400;
      step();
      for (int k = 1; k < 40; k++) begin
         update = 1'b1; ready = 1'b1; pc = 32'h400 + 32'(k * 4);
         check("wrap_pc", rec.pc, 32'h400 + 32'((k - 1) * 4));
         step();
      end
      update = 1'b0; ready = 1'b1;
      check("wrap_last_pc", rec.pc, 32'h400 + 32'(39 * 4));
      step();
      ready = 1'b0;
      check("wrap_count", count, 5'd0);
      check("wrap_drop", drop_cnt, 16'd0);
      check("wrap_overflow", overflow, 1'b0);

      // Clear priority over a concurrent push
      for (int i = 0; i < 17; i++) begin
         update = 1'b1; pc = 32'(i * 4);
         step();
      end
      update = 1'b0; ready = 1'b1;
      for (int i = 0; i < 11; i++) step();
      ready = 1'b0;
      check("pre_clr_count", count, 5'd5);
      check("pre_clr_overflow", overflow, 1'b1);
      check("pre_clr_drop", drop_cnt, 16'd1);
      clear = 1'b1; update = 1'b1; pc = 32'hDEAD_0000;
      step();
      clear = 1'b0; update = 1'b0;
      check("clrpri_count", count, 5'd0);
      check("clrpri_valid", valid, 1'b0);
      check("clrpri_overflow", overflow, 1'b0);
      check("clrpri_drop", drop_cnt, 16'd0);
      check("clrpri_drop3", drop_cnt3, 3'd0);

      // Saturation: 28 pushes into an empty FIFO give 12 drops
      for (int i = 0; i < 28; i++) begin
         update = 1'b1; pc = 32'h1000 + 32'(i * 4);
         step();
      end
      update = 1'b0;
      check("sat_count", count, 5'd16);
      check("sat_drop16", drop_cnt, 16'd12);
      check("sat_drop3", drop_cnt3, 3'd7);
      check("sat_overflow3", overflow3, 1'b1);

      // Asynchronous reset between edges
      #3;
      rstn = 1'b0;
      #1;
      check("arst_valid", valid, 1'b0);
      check("arst_count", count, 5'd0);
      check("arst_overflow", overflow, 1'b0);
      check("arst_drop", drop_cnt, 16'd0);
      check("arst_drop3", drop_cnt3, 3'd0);
      check("arst_valid3", valid3, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      step();
      check("post_rst_count", count, 5'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
